// File: rtl/uart_alu_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_alu_if
// Description : Bundle of the RX FIFO, TX FIFO and ALU signals used by
//               uart_alu_ctrl. The slave side is the controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_alu_if #(
   parameter int DATA_W = 16,
   parameter int OPC_W  = 6
);
   logic [7:0]        rx_data;
   logic              rx_empty;
   logic              rd_uart;
   logic              tx_full;
   logic              wr_uart;
   logic [7:0]        tx_data;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic [OPC_W-1:0]  op_code;
   logic [DATA_W-1:0] alu_result;
   logic [DATA_W-1:0] result_q;
   logic              busy;
   logic              frame_done;
   logic              err_timeout;

   modport slave (
      input  rx_data, rx_empty, tx_full, alu_result,
      output rd_uart, wr_uart, tx_data, op_a, op_b, op_code,
             result_q, busy, frame_done, err_timeout
   );

   modport master (
      output rx_data, rx_empty, tx_full, alu_result,
      input  rd_uart, wr_uart, tx_data, op_a, op_b, op_code,
             result_q, busy, frame_done, err_timeout
   );
endinterface
`default_nettype wire

// File: rtl/uart_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_alu_ctrl
// Description : Pops an opcode + A + B frame from the UART RX FIFO, commits the
//               operands to the ALU, registers the result and returns the
//               result bytes plus a status byte through the TX FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_alu_ctrl #(
   parameter int DATA_W      = 16,
   parameter int OPC_W       = 6,
   parameter int TIMEOUT_CYC = 0
) (
   input  wire logic clk,
   input  wire logic reset,
   uart_alu_if.slave bus
);
   localparam int c_NB    = DATA_W / 8;
   localparam int c_IDX_W = (c_NB > 1) ? $clog2(c_NB) : 1;
   localparam int c_TO_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(c_NB - 1);
   localparam logic [c_TO_W-1:0]  c_TO_LAST  = c_TO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RX_A    = 3'd1,
      S_RX_B    = 3'd2,
      S_EXEC    = 3'd3,
      S_TX_RES  = 3'd4,
      S_TX_STAT = 3'd5
   } state_t;

   state_t              r_state;
   logic [c_IDX_W-1:0]  r_idx;
   logic [c_TO_W-1:0]   r_to_cnt;
   logic [OPC_W-1:0]    r_sh_opc;
   logic [DATA_W-1:0]   r_sh_a;
   logic [DATA_W-1:0]   r_sh_b;
   logic [OPC_W-1:0]    r_op_code;
   logic [DATA_W-1:0]   r_op_a;
   logic [DATA_W-1:0]   r_op_b;
   logic [DATA_W-1:0]   r_result;

   logic                w_rx_state;
   logic                w_pop;
   logic                w_push;
   logic                w_timeout;
   logic [DATA_W-1:0]   w_b_full;
   logic [7:0]          w_status;
   logic [7:0]          w_tx_byte;

   // FIFO strobes, timeout detect, merged B operand and outgoing byte select
   always_comb begin
      w_rx_state = (r_state == S_IDLE) || (r_state == S_RX_A) || (r_state == S_RX_B);
      w_pop      = !reset && w_rx_state && !bus.rx_empty;
      w_push     = !reset && ((r_state == S_TX_RES) || (r_state == S_TX_STAT)) && !bus.tx_full;
      // A pop in the limit cycle takes precedence over the timeout
      w_timeout  = (TIMEOUT_CYC > 0) && !reset && ((r_state == S_RX_A) || (r_state == S_RX_B))
                   && !w_pop && (r_to_cnt == c_TO_LAST);
      // Last B byte is the MSB byte; merge it straight into the committed load
      w_b_full   = r_sh_b;
      w_b_full[(c_NB-1)*8 +: 8] = bus.rx_data;
      w_status   = {4'hA, 2'b00, r_result[DATA_W-1], (r_result == '0)};
      w_tx_byte  = 8'h00;
      if (r_state == S_TX_RES) begin
         w_tx_byte = r_result[r_idx*8 +: 8];
      end else if (r_state == S_TX_STAT) begin
         w_tx_byte = w_status;
      end
   end

   // Frame sequencer: receive, commit, execute, transmit
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_idx     <= '0;
         r_to_cnt  <= '0;
         r_sh_opc  <= '0;
         r_sh_a    <= '0;
         r_sh_b    <= '0;
         r_op_code <= '0;
         r_op_a    <= '0;
         r_op_b    <= '0;
         r_result  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  r_sh_opc <= bus.rx_data[OPC_W-1:0];
                  r_idx    <= '0;
                  r_to_cnt <= '0;
                  r_state  <= S_RX_A;
               end
            end
            S_RX_A, S_RX_B: begin
               if (w_pop) begin
                  r_to_cnt <= '0;
                  if (r_state == S_RX_A) begin
                     r_sh_a[r_idx*8 +: 8] <= bus.rx_data;
                  end else begin
                     r_sh_b[r_idx*8 +: 8] <= bus.rx_data;
                  end
                  if (r_idx == c_IDX_LAST) begin
                     r_idx <= '0;
                     if (r_state == S_RX_A) begin
                        r_state <= S_RX_B;
                     end else begin
                        r_op_a    <= r_sh_a;
                        r_op_b    <= w_b_full;
                        r_op_code <= r_sh_opc;
                        r_state   <= S_EXEC;
                     end
                  end else begin
                     r_idx <= r_idx + 1'b1;
                  end
               end else if (w_timeout) begin
                  r_sh_opc <= '0;
                  r_sh_a   <= '0;
                  r_sh_b   <= '0;
                  r_idx    <= '0;
                  r_to_cnt <= '0;
                  r_state  <= S_IDLE;
               end else if (TIMEOUT_CYC > 0) begin
                  r_to_cnt <= r_to_cnt + 1'b1;
               end
            end
            S_EXEC: begin
               r_result <= bus.alu_result;
               r_idx    <= '0;
               r_state  <= S_TX_RES;
            end
            S_TX_RES: begin
               if (w_push) begin
                  if (r_idx == c_IDX_LAST) begin
                     r_idx   <= '0;
                     r_state <= S_TX_STAT;
                  end else begin
                     r_idx <= r_idx + 1'b1;
                  end
               end
            end
            S_TX_STAT: begin
               if (w_push) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.rd_uart     = w_pop;
   assign bus.wr_uart     = w_push;
   assign bus.tx_data     = w_tx_byte;
   assign bus.op_a        = r_op_a;
   assign bus.op_b        = r_op_b;
   assign bus.op_code     = r_op_code;
   assign bus.result_q    = r_result;
   assign bus.busy        = (r_state != S_IDLE);
   assign bus.frame_done  = w_push && (r_state == S_TX_STAT);
   assign bus.err_timeout = w_timeout;

endmodule
`default_nettype wire

// File: tb/tb_uart_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_alu_ctrl
// Description : Self-checking bench for uart_alu_ctrl. Instance A is 16-bit
//               with a 100-cycle timeout, instance B is 8-bit without one.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_alu_ctrl;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   uart_alu_if #(.DATA_W(16), .OPC_W(6)) bus_a ();
   uart_alu_if #(.DATA_W(8),  .OPC_W(6)) bus_b ();

   uart_alu_ctrl #(.DATA_W(16), .OPC_W(6), .TIMEOUT_CYC(100)) dut_a (
      .clk(clk), .reset(reset), .bus(bus_a.slave));
   uart_alu_ctrl #(.DATA_W(8),  .OPC_W(6), .TIMEOUT_CYC(0))   dut_b (
      .clk(clk), .reset(reset), .bus(bus_b.slave));

   // ALU model: 0x20 add, 0x22 sub, anything else xor
   function automatic logic [15:0] alu_ref(logic [5:0] op, logic [15:0] a, logic [15:0] b);
      case (op)
         6'h20:   return a + b;
         6'h22:   return a - b;
         default: return a ^ b;
      endcase
   endfunction

   logic [15:0] w_alu_b_full;
   assign bus_a.alu_result = alu_ref(bus_a.op_code, bus_a.op_a, bus_a.op_b);
   assign w_alu_b_full     = alu_ref(bus_b.op_code, {8'h00, bus_b.op_a}, {8'h00, bus_b.op_b});
   assign bus_b.alu_result = w_alu_b_full[7:0];

   int errors = 0;
   int checks = 0;

   task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   logic [7:0] rxq_a[$], rxq_b[$], txq_a[$], txq_b[$];
   int gap_pct_a = 0, full_pct_a = 0;
   bit full_force_a = 1'b0;
   int cyc = 0, last_pop_a = -1, first_wr_a = -1, err_cyc_a = -1;
   int n_done_a = 0, n_err_a = 0, illegal_a = 0;
   int n_done_b = 0, n_pop_b = 0, illegal_b = 0;
   logic [15:0] exp_op_a = 16'h0;

   // One clock: drive inputs after the falling edge, sample 1 ns later
   task automatic tick();
      @(negedge clk);
      cyc++;
      bus_a.rx_empty = (rxq_a.size() == 0) || ($urandom_range(99) < gap_pct_a);
      bus_a.rx_data  = (rxq_a.size() != 0) ? rxq_a[0] : 8'h00;
      bus_a.tx_full  = full_force_a || ($urandom_range(99) < full_pct_a);
      bus_b.rx_empty = (rxq_b.size() == 0);
      bus_b.rx_data  = (rxq_b.size() != 0) ? rxq_b[0] : 8'h00;
      bus_b.tx_full  = 1'b0;
      #1;
      if (bus_a.rd_uart && bus_a.wr_uart) illegal_a++;
      if (bus_a.rd_uart) begin
         if (bus_a.rx_empty) illegal_a++;
         else begin
            void'(rxq_a.pop_front());
            last_pop_a = cyc;
         end
      end
      if (bus_a.wr_uart) begin
         if (bus_a.tx_full) illegal_a++;
         else begin
            txq_a.push_back(bus_a.tx_data);
            if (first_wr_a < 0) first_wr_a = cyc;
         end
      end
      if (bus_a.frame_done) n_done_a++;
      if (bus_a.err_timeout) begin
         n_err_a++;
         err_cyc_a = cyc;
      end
      if (bus_b.rd_uart && bus_b.wr_uart) illegal_b++;
      if (bus_b.rd_uart) begin
         if (bus_b.rx_empty) illegal_b++;
         else begin
            void'(rxq_b.pop_front());
            n_pop_b++;
         end
      end
      if (bus_b.wr_uart) txq_b.push_back(bus_b.tx_data);
      if (bus_b.frame_done) n_done_b++;
   endtask

   task automatic wait_tx_a(int n);
      int k = 0;
      while (txq_a.size() < n && k < 3000) begin
         tick();
         k++;
      end
   endtask

   task automatic queue_frame_a(logic [7:0] opb, logic [15:0] a, logic [15:0] b);
      rxq_a.push_back(opb);
      rxq_a.push_back(a[7:0]);
      rxq_a.push_back(a[15:8]);
      rxq_a.push_back(b[7:0]);
      rxq_a.push_back(b[15:8]);
   endtask

   // Expected result bytes and status from the frame contents
   task automatic check_frame_a(string tag, logic [7:0] opb, logic [15:0] a, logic [15:0] b);
      logic [15:0] res;
      logic [7:0]  stat;
      res  = alu_ref(opb[5:0], a, b);
      stat = {4'hA, 2'b00, res[15], (res == 16'h0)};
      check_val({tag, ":ntx"}, txq_a.size(), 3);
      check_val({tag, ":op_a"}, bus_a.op_a, a);
      check_val({tag, ":op_b"}, bus_a.op_b, b);
      check_val({tag, ":op_code"}, bus_a.op_code, opb[5:0]);
      check_val({tag, ":result_q"}, bus_a.result_q, res);
      if (txq_a.size() == 3) begin
         check_val({tag, ":tx0"}, txq_a[0], res[7:0]);
         check_val({tag, ":tx1"}, txq_a[1], res[15:8]);
         check_val({tag, ":tx2"}, txq_a[2], stat);
      end
      exp_op_a = a;
   endtask

   task automatic run_frame_a(string tag, logic [7:0] opb, logic [15:0] a, logic [15:0] b);
      int d0;
      d0 = n_done_a;
      txq_a.delete();
      first_wr_a = -1;
      queue_frame_a(opb, a, b);
      wait_tx_a(3);
      check_frame_a(tag, opb, a, b);
      check_val({tag, ":done"}, n_done_a - d0, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad, d0;
      logic [7:0]  opb;
      logic [15:0] ra, rb;

      // Reset state: strobes must stay low even with data waiting
      reset = 1'b1;
      bus_a.rx_empty = 1'b0; bus_a.rx_data = 8'h20; bus_a.tx_full = 1'b0;
      bus_b.rx_empty = 1'b0; bus_b.rx_data = 8'h20; bus_b.tx_full = 1'b0;
      #1;
      check_val("rst:rd_a", bus_a.rd_uart, 0);
      check_val("rst:busy_a", bus_a.busy, 0);
      check_val("rst:op_a", bus_a.op_a, 0);
      check_val("rst:result_a", bus_a.result_q, 0);
      check_val("rst:rd_b", bus_b.rd_uart, 0);
      repeat (3) @(negedge clk);
      bus_a.rx_empty = 1'b1;
      bus_b.rx_empty = 1'b1;
      reset = 1'b0;

      // Directed frames
      run_frame_a("t1", 8'h20, 16'h1234, 16'h0001);
      check_val("t1:latency", first_wr_a - last_pop_a, 2);
      run_frame_a("t2", 8'h22, 16'h00FF, 16'h00FF);

      // TX back-pressure after the first push
      txq_a.delete();
      d0 = n_done_a;
      queue_frame_a(8'h20, 16'h1234, 16'h0001);
      wait_tx_a(1);
      full_force_a = 1'b1;
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (bus_a.wr_uart || bus_a.tx_data !== 8'h12) bad++;
      end
      check_val("t3:hold", bad, 0);
      check_val("t3:no_push", txq_a.size(), 1);
      full_force_a = 1'b0;
      wait_tx_a(3);
      repeat (3) tick();
      check_frame_a("t3", 8'h20, 16'h1234, 16'h0001);
      check_val("t3:done", n_done_a - d0, 1);

      // Inter-byte timeout; the following byte must start a new frame
      d0 = n_err_a;
      rxq_a.push_back(8'h20);
      rxq_a.push_back(8'h34);
      while (rxq_a.size() != 0) tick();
      repeat (101) tick();
      check_val("t4:err_cnt", n_err_a - d0, 1);
      check_val("t4:err_delay", err_cyc_a - last_pop_a, 100);
      check_val("t4:op_a_kept", bus_a.op_a, exp_op_a);
      check_val("t4:busy", bus_a.busy, 0);
      run_frame_a("t4b", 8'h22, 16'h5000, 16'h0123);

      // Reset in the middle of transmission
      txq_a.delete();
      queue_frame_a(8'h20, 16'h1234, 16'h0001);
      wait_tx_a(1);
      @(negedge clk);
      bus_a.rx_empty = 1'b0;
      bus_a.tx_full  = 1'b0;
      reset = 1'b1;
      #1;
      check_val("t5:wr", bus_a.wr_uart, 0);
      check_val("t5:rd", bus_a.rd_uart, 0);
      check_val("t5:busy", bus_a.busy, 0);
      check_val("t5:op_a", bus_a.op_a, 0);
      check_val("t5:result", bus_a.result_q, 0);
      rxq_a.delete();
      repeat (3) tick();
      check_val("t5:no_push", txq_a.size(), 1);
      @(negedge clk);
      bus_a.rx_empty = 1'b1;
      bus_b.rx_empty = 1'b1;
      reset = 1'b0;
      exp_op_a = 16'h0;
      run_frame_a("t5b", 8'h20, 16'h1234, 16'h0001);

      // Randomized frames with RX gaps and TX back-pressure
      gap_pct_a  = 30;
      full_pct_a = 30;
      for (int i = 0; i < 10; i++) begin
         case ($urandom_range(2))
            0:       opb = 8'h20;
            1:       opb = 8'h22;
            default: opb = 8'($urandom_range(63));
         endcase
         opb[7:6] = 2'($urandom_range(3));
         ra = 16'($urandom);
         rb = 16'($urandom);
         run_frame_a("rnd", opb, ra, rb);
      end
      gap_pct_a  = 0;
      full_pct_a = 0;

      // 8-bit instance: two back-to-back frames, RX never empty
      rxq_b.push_back(8'h20); rxq_b.push_back(8'h80); rxq_b.push_back(8'h01);
      rxq_b.push_back(8'h22); rxq_b.push_back(8'h05); rxq_b.push_back(8'h07);
      for (int k = 0; k < 100 && txq_b.size() < 4; k++) tick();
      check_val("t6:ntx", txq_b.size(), 4);
      check_val("t6:pops", n_pop_b, 6);
      check_val("t6:done", n_done_b, 2);
      if (txq_b.size() == 4) begin
         check_val("t6:tx0", txq_b[0], 8'h81);
         check_val("t6:tx1", txq_b[1], 8'hA2);
         check_val("t6:tx2", txq_b[2], 8'hFE);
         check_val("t6:tx3", txq_b[3], 8'hA2);
      end
      check_val("t6:op_a", bus_b.op_a, 8'h05);
      check_val("t6:op_b", bus_b.op_b, 8'h07);

      check_val("proto_a", illegal_a, 0);
      check_val("proto_b", illegal_b, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
